// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: converts 128-bit cacheline read/write requests from the
// L1 cache into 4-beat, 32-bit burst transactions to physical memory. It
// returns a one-cycle pmem_resp once the whole line has moved.
//
// Handshake: a request (pmem_read/pmem_write) is held by the cache until
// pmem_resp. On the memory side, one beat moves on every cycle in which
// mem_resp is high while mem_read/mem_write is asserted. Cycles with
// mem_resp low are wait states. All outputs are registers.
module cacheline_adaptor #(
    parameter int LINE_W = 128,
    parameter int BEAT_W = 32,
    parameter int BEATS  = LINE_W / BEAT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [15:0]       pmem_address,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic              pmem_resp,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic [15:0]       mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [BEAT_W-1:0] mem_burst_o,
    input  logic [BEAT_W-1:0] mem_burst_i,
    input  logic              mem_resp
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [LINE_W-1:0] r_line;     // write line, frozen for the whole burst
    logic [CNT_W-1:0]  w_next_cnt;
    logic [15:0]       w_line_addr;

    assign w_next_cnt  = r_cnt + CNT_W'(1);
    // Clear the byte-in-line offset so the burst starts on a line boundary.
    assign w_line_addr = pmem_address & 16'hFFF0;

    // Single FSM: sequences the bursts and drives every output as a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_line      <= '0;
            pmem_resp   <= 1'b0;
            pmem_rdata  <= '0;
            mem_address <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_burst_o <= '0;
        end else begin
            pmem_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Writeback wins over fill when both are requested.
                    if (pmem_write) begin
                        r_line      <= pmem_wdata;
                        mem_address <= w_line_addr;
                        r_cnt       <= '0;
                        mem_write   <= 1'b1;
                        mem_burst_o <= pmem_wdata[BEAT_W-1:0];
                        r_state     <= WR;
                    end else if (pmem_read) begin
                        mem_address <= w_line_addr;
                        r_cnt       <= '0;
                        mem_read    <= 1'b1;
                        r_state     <= RD;
                    end
                end
                RD: begin
                    if (mem_resp) begin
                        // Assemble the fill directly in the output register.
                        pmem_rdata[r_cnt*BEAT_W +: BEAT_W] <= mem_burst_i;
                        if (r_cnt == LAST_BEAT) begin
                            r_cnt     <= '0;
                            mem_read  <= 1'b0;
                            pmem_resp <= 1'b1;
                            r_state   <= RESP;
                        end else begin
                            r_cnt <= w_next_cnt;
                        end
                    end
                end
                WR: begin
                    if (mem_resp) begin
                        if (r_cnt == LAST_BEAT) begin
                            r_cnt     <= '0;
                            mem_write <= 1'b0;
                            pmem_resp <= 1'b1;
                            r_state   <= RESP;
                        end else begin
                            // Present the next beat on the cycle after the handshake.
                            r_cnt       <= w_next_cnt;
                            mem_burst_o <= r_line[w_next_cnt*BEAT_W +: BEAT_W];
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: a per-cycle vector table for the
// basic fill, plus directed sequences for stalled writes, read/write
// collision, back-to-back bursts and reset in the middle of a burst.
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst_n;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_burst_o;
    logic [31:0]  mem_burst_i;
    logic         mem_resp;

    int errors = 0;
    int checks = 0;
    int resp_pulses = 0;
    logic [31:0] exp_q[$];

    cacheline_adaptor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_burst_o  (mem_burst_o),
        .mem_burst_i  (mem_burst_i),
        .mem_resp     (mem_resp)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [15:0]  addr;
        logic [31:0]  bi;
        logic         resp;
        logic         exp_presp;
        logic         exp_mrd;
        logic         exp_mwr;
        logic [15:0]  exp_maddr;
        logic         chk_rdata;
        logic [127:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pmem_resp === 1'b1) resp_pulses++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pmem_resp"},   128'(pmem_resp),   128'd0);
        check({tag, "_pmem_rdata"},  pmem_rdata,        128'd0);
        check({tag, "_mem_address"}, 128'(mem_address), 128'd0);
        check({tag, "_mem_read"},    128'(mem_read),    128'd0);
        check({tag, "_mem_write"},   128'(mem_write),   128'd0);
        check({tag, "_mem_burst_o"}, 128'(mem_burst_o), 128'd0);
    endtask

    // Full line fill with 'stall' wait cycles before every beat.
    task automatic read_burst(input logic [15:0] addr, input logic [127:0] line, input int stall);
        logic [15:0] exp_addr;
        exp_addr = {addr[15:4], 4'h0};
        pmem_read = 1'b1; pmem_write = 1'b0; pmem_address = addr; mem_resp = 1'b0;
        tick();
        check("rd_start_mem_read", 128'(mem_read), 128'd1);
        check("rd_start_mem_addr", 128'(mem_address), 128'(exp_addr));
        pmem_address = 16'(~addr);
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < stall; s++) begin
                mem_resp = 1'b0;
                mem_burst_i = 32'($urandom);
                tick();
                check("rd_wait_mem_read", 128'(mem_read), 128'd1);
                check("rd_wait_pmem_resp", 128'(pmem_resp), 128'd0);
            end
            mem_resp = 1'b1;
            mem_burst_i = line[b*32 +: 32];
            tick();
            mem_resp = 1'b0;
            if (b < 3) begin
                check("rd_beat_mem_read", 128'(mem_read), 128'd1);
                check("rd_beat_pmem_resp", 128'(pmem_resp), 128'd0);
            end else begin
                check("rd_done_mem_read", 128'(mem_read), 128'd0);
                check("rd_done_pmem_resp", 128'(pmem_resp), 128'd1);
                check("rd_done_rdata", pmem_rdata, line);
                check("rd_done_mem_addr", 128'(mem_address), 128'(exp_addr));
            end
        end
        pmem_read = 1'b0;
        mem_resp = 1'b1;  // ignored while the response is presented
        tick();
        mem_resp = 1'b0;
        check("rd_after_pmem_resp", 128'(pmem_resp), 128'd0);
        check("rd_after_mem_read", 128'(mem_read), 128'd0);
        check("rd_after_rdata", pmem_rdata, line);
    endtask

    // Full line writeback with 'stall' wait cycles before every beat.
    task automatic write_burst(input logic [15:0] addr, input logic [127:0] line, input int stall,
                               input logic rd_too, input logic next_rd, input logic [15:0] next_addr);
        logic [15:0] exp_addr;
        exp_addr = {addr[15:4], 4'h0};
        for (int b = 0; b < 4; b++) exp_q.push_back(line[b*32 +: 32]);
        pmem_write = 1'b1; pmem_read = rd_too; pmem_address = addr; pmem_wdata = line;
        mem_resp = 1'b0;
        tick();
        check("wr_start_mem_write", 128'(mem_write), 128'd1);
        check("wr_start_mem_read", 128'(mem_read), 128'd0);
        check("wr_start_mem_addr", 128'(mem_address), 128'(exp_addr));
        pmem_address = 16'(~addr);
        pmem_wdata = ~line;
        for (int b = 0; b < 4; b++) begin
            for (int s = 0; s < stall; s++) begin
                mem_resp = 1'b0;
                tick();
                check("wr_wait_burst_o", 128'(mem_burst_o), 128'(exp_q[0]));
                check("wr_wait_mem_write", 128'(mem_write), 128'd1);
                check("wr_wait_mem_read", 128'(mem_read), 128'd0);
            end
            check("wr_beat_burst_o", 128'(mem_burst_o), 128'(exp_q[0]));
            void'(exp_q.pop_front());
            mem_resp = 1'b1;
            tick();
            mem_resp = 1'b0;
            check("wr_beat_mem_read", 128'(mem_read), 128'd0);
            if (b < 3) begin
                check("wr_beat_mem_write", 128'(mem_write), 128'd1);
                check("wr_beat_pmem_resp", 128'(pmem_resp), 128'd0);
            end else begin
                check("wr_done_mem_write", 128'(mem_write), 128'd0);
                check("wr_done_pmem_resp", 128'(pmem_resp), 128'd1);
            end
        end
        pmem_write = 1'b0;
        pmem_read = next_rd;
        pmem_address = next_addr;
        mem_resp = 1'b1;  // ignored while the response is presented
        tick();
        mem_resp = 1'b0;
        check("wr_after_pmem_resp", 128'(pmem_resp), 128'd0);
        check("wr_after_mem_read", 128'(mem_read), 128'd0);
        check("wr_after_mem_write", 128'(mem_write), 128'd0);
    endtask

    initial begin
        int pulses_before;
        logic [127:0] line;

        // Fill: request at vec 1, beats in vecs 2..5, response in the cycle after the last beat.
        vecs[0] = '{1'b0, 1'b0, 16'h0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 128'h0};
        vecs[1] = '{1'b1, 1'b0, 16'h1236, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1230, 1'b0, 128'h0};
        vecs[2] = '{1'b1, 1'b0, 16'h1236, 32'h11111111, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1230, 1'b0, 128'h0};
        vecs[3] = '{1'b1, 1'b0, 16'hFFFF, 32'h22222222, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1230, 1'b0, 128'h0};
        vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 32'h33333333, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1230, 1'b0, 128'h0};
        vecs[5] = '{1'b1, 1'b0, 16'hFFFF, 32'h44444444, 1'b1, 1'b1, 1'b0, 1'b0, 16'h1230, 1'b1,
                    128'h44444444_33333333_22222222_11111111};
        vecs[6] = '{1'b0, 1'b0, 16'h0000, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1230, 1'b1,
                    128'h44444444_33333333_22222222_11111111};
        vecs[7] = '{1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1230, 1'b0, 128'h0};

        // Reset with random inputs
        rst_n = 1'b0;
        pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = '0; pmem_wdata = '0;
        mem_burst_i = '0; mem_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pmem_read = 1'($urandom); pmem_write = 1'($urandom);
            pmem_address = 16'($urandom);
            pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
            mem_burst_i = $urandom; mem_resp = 1'($urandom);
            tick();
            check_all_zero("reset");
        end
        pmem_read = 1'b0; pmem_write = 1'b0; mem_resp = 1'b0;
        rst_n = 1'b1;
        tick();
        check_all_zero("post_reset");

        // Table-driven fill
        for (int i = 0; i < 8; i++) begin
            pmem_read = vecs[i].rd; pmem_write = vecs[i].wr;
            pmem_address = vecs[i].addr; mem_burst_i = vecs[i].bi; mem_resp = vecs[i].resp;
            tick();
            check($sformatf("vec%0d_pmem_resp", i), 128'(pmem_resp), 128'(vecs[i].exp_presp));
            check($sformatf("vec%0d_mem_read", i),  128'(mem_read),  128'(vecs[i].exp_mrd));
            check($sformatf("vec%0d_mem_write", i), 128'(mem_write), 128'(vecs[i].exp_mwr));
            check($sformatf("vec%0d_mem_addr", i),  128'(mem_address), 128'(vecs[i].exp_maddr));
            if (vecs[i].chk_rdata) check($sformatf("vec%0d_rdata", i), pmem_rdata, vecs[i].exp_rdata);
        end

        // Stalled writeback: two wait cycles before each beat
        pulses_before = resp_pulses;
        write_burst(16'h2345, 128'hDDDD0000_CCCC0000_BBBB0000_AAAA0000, 2, 1'b0, 1'b0, 16'h0);
        check("wr_single_pulse", 128'(resp_pulses - pulses_before), 128'd1);

        // Read and write together: writeback first, no mem_read during it
        write_burst(16'h0A5F, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 0, 1'b1, 1'b0, 16'h0);
        read_burst(16'h0A5F, 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000, 0);

        // Writeback then fill to 16'h4000, back to back
        pulses_before = resp_pulses;
        write_burst(16'h7FF8, 128'h0F0F0F0F_F0F0F0F0_55555555_AAAAAAAA, 1, 1'b0, 1'b1, 16'h4000);
        read_burst(16'h4000, 128'h40000003_40000002_40000001_40000000, 1);
        check("b2b_pulses", 128'(resp_pulses - pulses_before), 128'd2);

        // Reset in the middle of a fill, then a clean fill
        pmem_read = 1'b1; pmem_address = 16'h5678; mem_resp = 1'b0;
        tick();
        for (int b = 0; b < 2; b++) begin
            mem_resp = 1'b1; mem_burst_i = 32'hBAD00000 | 32'(b);
            tick();
        end
        mem_resp = 1'b0;
        check("midrst_pre_mem_read", 128'(mem_read), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst_async");
        pmem_read = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check_all_zero("midrst_release");
        line = 128'h13572468_24681357_9ABCDEF0_0FEDCBA9;
        read_burst(16'h5678, line, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
